// File: rtl/tea_iter_decrypt_ctrl_pkg.sv
// Shared TEA definitions: key-schedule constant, FSM states, block/key types.
// Latency: none (types and constants only). Backpressure: n/a.
// Helper computes the starting sum for a given round count.
package tea_pkg;

    localparam logic [31:0] TEA_DELTA      = 32'h9e3779b9;
    localparam int          TEA_ROUNDS_MAX = 32;

    typedef enum logic [1:0] {IDLE, RUN, DONE} tea_state_t;

    typedef logic [63:0]  tea_block_t;
    typedef logic [127:0] tea_key_t;

    // Decryption walks the sum back down from DELTA*rounds, modulo 2^32.
    function automatic logic [31:0] tea_sum_init(input int rounds);
        logic [31:0] r;
        r = 32'(rounds);
        return TEA_DELTA * r;
    endfunction

endpackage

// File: rtl/tea_iter_decrypt_ctrl_if.sv
// Block/key request channel and plaintext result channel of the iterative decryptor.
// Latency: n/a. Backpressure: valid/ready on both the request and the result side.
// The slave modport is the engine; the master modport is the block producer/consumer.
interface tea_iter_decrypt_ctrl_if;
    import tea_pkg::*;

    logic       in_valid;
    logic       in_ready;
    tea_block_t in_block;
    tea_key_t   in_key;
    logic       out_valid;
    logic       out_ready;
    tea_block_t out_block;
    logic       busy;
    logic [4:0] round_idx;

    modport master (
        output in_valid, in_block, in_key, out_ready,
        input  in_ready, out_valid, out_block, busy, round_idx
    );

    modport slave (
        input  in_valid, in_block, in_key, out_ready,
        output in_ready, out_valid, out_block, busy, round_idx
    );

endinterface

// File: rtl/tea_iter_decrypt_ctrl_round.sv
// One combinational TEA decryption round (V1 first, then V0 using the new V1).
// Latency: 0 cycles. Backpressure: none, purely combinational.
// Key words: k0=key[31:0], k1=key[63:32], k2=key[95:64], k3=key[127:96].
module decryptor_single_round
    import tea_pkg::*;
(
    input  tea_key_t    key,
    input  logic [31:0] inV0,
    input  logic [31:0] inV1,
    input  logic [31:0] sum,
    output logic [31:0] outputV0,
    output logic [31:0] outputV1
);

    logic [31:0] k0, k1, k2, k3;

    assign k0 = key[31:0];
    assign k1 = key[63:32];
    assign k2 = key[95:64];
    assign k3 = key[127:96];

    assign outputV1 = inV1 - (((inV0 << 4) + k2) ^ (inV0 + sum) ^ ((inV0 >> 5) + k3));
    assign outputV0 = inV0 - (((outputV1 << 4) + k0) ^ (outputV1 + sum) ^ ((outputV1 >> 5) + k1));

endmodule

// File: rtl/tea_iter_decrypt_ctrl.sv
// Iterative TEA decryptor: one shared round reused ROUNDS times on registered V0/V1.
// Latency: result valid ROUNDS edges after the accepting edge; one block per ROUNDS+1 cycles.
// Backpressure: result held until out_ready; a new block is taken in the same cycle it drains.
module tea_iter_decrypt_ctrl
    import tea_pkg::*;
#(
    parameter int ROUNDS = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tea_iter_decrypt_ctrl_if.slave  bus
);

    localparam logic [31:0] SUM_INIT = tea_sum_init(ROUNDS);
    localparam logic [4:0]  LAST_IDX = 5'(ROUNDS - 1);

    tea_state_t  state;
    logic [31:0] v0_q, v1_q, sum_q;
    tea_key_t    key_q;
    logic [4:0]  round_idx_q;
    logic        out_valid_q;
    logic        busy_q;

    logic [31:0] round_v0, round_v1;
    logic        accept;

    decryptor_single_round u_round (
        .key      (key_q),
        .inV0     (v0_q),
        .inV1     (v1_q),
        .sum      (sum_q),
        .outputV0 (round_v0),
        .outputV1 (round_v1)
    );

    // Taking a new block while draining the old one avoids a bubble cycle.
    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_block = {v1_q, v0_q};
    assign bus.busy      = busy_q;
    assign bus.round_idx = round_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            v0_q        <= '0;
            v1_q        <= '0;
            sum_q       <= '0;
            key_q       <= '0;
            round_idx_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            v0_q        <= bus.in_block[31:0];
            v1_q        <= bus.in_block[63:32];
            key_q       <= bus.in_key;
            sum_q       <= SUM_INIT;
            round_idx_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            state       <= RUN;
        end else begin
            case (state)
                RUN: begin
                    v0_q        <= round_v0;
                    v1_q        <= round_v1;
                    sum_q       <= sum_q - TEA_DELTA;
                    round_idx_q <= round_idx_q + 5'd1;
                    if (round_idx_q == LAST_IDX) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tea_iter_decrypt_ctrl.sv
// Bench for the iterative TEA decryptor: known vectors, random blocks against a TEA encryptor
// reference, backpressure, mid-run input changes, mid-run reset, and a single-round build.
module tb_tea_iter_decrypt_ctrl;
    import tea_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    tea_iter_decrypt_ctrl_if bus ();
    tea_iter_decrypt_ctrl_if bus1 ();

    tea_iter_decrypt_ctrl #(.ROUNDS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    tea_iter_decrypt_ctrl #(.ROUNDS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        tea_key_t   key;
        tea_block_t ct;
        tea_block_t pt;
    } vec_t;

    vec_t vecs[4];

    // Reference: forward TEA encryption; decrypting its output must give the plaintext back.
    function automatic tea_block_t tea_encrypt(input tea_block_t pt, input tea_key_t k,
                                               input int rounds);
        logic [31:0] v0, v1, s;
        v0 = pt[31:0];
        v1 = pt[63:32];
        s  = 32'h0;
        for (int r = 0; r < rounds; r++) begin
            s  = s + TEA_DELTA;
            v0 = v0 + (((v1 << 4) + k[31:0]) ^ (v1 + s) ^ ((v1 >> 5) + k[63:32]));
            v1 = v1 + (((v0 << 4) + k[95:64]) ^ (v0 + s) ^ ((v0 >> 5) + k[127:96]));
        end
        return {v1, v0};
    endfunction

    function automatic tea_key_t rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic tea_block_t rand_block();
        return {$urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a block and advance through the edge that accepts it.
    task automatic accept_block(input tea_block_t blk, input tea_key_t k);
        int n;
        bus.in_block = blk;
        bus.in_key   = k;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!bus.in_ready) check("accept_timeout", 64'(n), 64'd0);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Count edges until out_valid rises, then compare latency and data.
    task automatic wait_out(input string name, input tea_block_t exp, input int exp_lat);
        int n;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
        check({name, "_lat"}, 64'(n), 64'(exp_lat));
        check(name, bus.out_block, exp);
    endtask

    initial begin
        tea_block_t cur_pt, nxt_pt, nxt_ct, held;
        tea_key_t   nxt_key;
        int         seen, n;

        checks   = 0;
        failures = 0;

        vecs[0] = '{key: 128'h0, ct: 64'h94baa940_41ea3a0a, pt: 64'h0};
        vecs[1] = '{key: 128'h00010203_04050607_08090a0b_0c0d0e0f, ct: 64'h0,
                    pt: 64'h01234567_89abcdef};
        vecs[2] = '{key: {128{1'b1}}, ct: 64'h0, pt: {64{1'b1}}};
        vecs[3] = '{key: 128'hdeadbeef_00000000_ffffffff_12345678, ct: 64'h0,
                    pt: 64'h80000000_00000001};
        for (int i = 1; i < 4; i++) vecs[i].ct = tea_encrypt(vecs[i].pt, vecs[i].key, 32);

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.in_block  = '0;
        bus1.in_key    = '0;
        bus1.out_ready = 1'b1;
        tick();
        tick();

        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_round_idx", 64'(bus.round_idx), 64'd0);
        check("rst_out_block", bus.out_block,      64'd0);
        rst_n = 1'b1;
        tick();

        // Known vectors.
        for (int i = 0; i < 4; i++) begin
            accept_block(vecs[i].ct, vecs[i].key);
            check("vec_busy", 64'(bus.busy), 64'd1);
            wait_out("vec", vecs[i].pt, 32);
            tick();
            check("vec_drained", 64'(bus.out_valid), 64'd0);
        end

        // Random back-to-back stream with out_ready held high.
        bus.out_ready = 1'b1;
        cur_pt  = rand_block();
        nxt_key = rand_key();
        bus.in_block = tea_encrypt(cur_pt, nxt_key, 32);
        bus.in_key   = nxt_key;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            check("rnd_in_ready", 64'(bus.in_ready), 64'd1);
            tick();
            nxt_pt  = rand_block();
            nxt_key = rand_key();
            bus.in_block = tea_encrypt(nxt_pt, nxt_key, 32);
            bus.in_key   = nxt_key;
            wait_out("rnd", cur_pt, 32);
            cur_pt = nxt_pt;
        end
        bus.in_valid = 1'b0;
        tick();

        // Result backpressure with a pending block.
        bus.out_ready = 1'b0;
        accept_block(vecs[0].ct, vecs[0].key);
        wait_out("bp_first", vecs[0].pt, 32);
        nxt_pt  = rand_block();
        nxt_key = rand_key();
        nxt_ct  = tea_encrypt(nxt_pt, nxt_key, 32);
        bus.in_block = nxt_ct;
        bus.in_key   = nxt_key;
        bus.in_valid = 1'b1;
        held = bus.out_block;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_out_block", bus.out_block, vecs[0].pt);
            check("bp_in_ready",  64'(bus.in_ready), 64'd0);
        end
        check("bp_block_stable", bus.out_block, held);
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
        check("bp_release_busy",      64'(bus.busy),      64'd1);
        check("bp_release_round_idx", 64'(bus.round_idx), 64'd0);
        wait_out("bp_second", nxt_pt, 32);
        tick();

        // Key and block change while running.
        accept_block(vecs[0].ct, vecs[0].key);
        repeat (10) tick();
        check("mid_round_idx", 64'(bus.round_idx), 64'd10);
        bus.in_key   = rand_key();
        bus.in_block = rand_block();
        wait_out("mid_change", vecs[0].pt, 22);
        tick();

        // Reset in the middle of a block.
        accept_block(vecs[0].ct, vecs[0].key);
        repeat (17) tick();
        check("rst17_round_idx", 64'(bus.round_idx), 64'd17);
        rst_n = 1'b0;
        #1;
        check("rst17_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst17_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst17_busy",      64'(bus.busy),      64'd0);
        check("rst17_round_idx_clr", 64'(bus.round_idx), 64'd0);
        check("rst17_out_block", bus.out_block,      64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("rst17_no_spurious", 64'(seen), 64'd0);
        accept_block(vecs[0].ct, vecs[0].key);
        wait_out("rst17_after", vecs[0].pt, 32);
        tick();

        // Single-round build.
        for (int i = 0; i < 4; i++) begin
            nxt_pt  = rand_block();
            nxt_key = rand_key();
            bus1.in_block = tea_encrypt(nxt_pt, nxt_key, 1);
            bus1.in_key   = nxt_key;
            bus1.in_valid = 1'b1;
            check("r1_in_ready", 64'(bus1.in_ready), 64'd1);
            tick();
            bus1.in_valid = 1'b0;
            n = 0;
            while (!bus1.out_valid && n < 20) begin
                tick();
                n++;
            end
            check("r1_lat", 64'(n), 64'd1);
            check("r1_data", bus1.out_block, nxt_pt);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
